// File: rtl/wb_pkg.sv
// Shared types and default widths for the write-back arbiter and its LU buffer.
package wb_pkg;

    localparam int WB_DATA_W       = 32;
    localparam int WB_REG_W        = 5;
    localparam int WB_FIFO_DEPTH   = 4;
    localparam int WB_STARVE_LIMIT = 8;

    typedef struct packed {
        logic [WB_REG_W-1:0]  rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // A source register of x0 never creates a hazard.
    function automatic logic rd_match(input logic [WB_REG_W-1:0] dst,
                                      input logic [WB_REG_W-1:0] src);
        return (src != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of pending LU write-backs; exposes every occupied slot's rd for hazard checks.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wb_entry_t              i_data,
    output wb_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [WB_REG_W-1:0]    o_ent_rd [DEPTH],
    output logic [DEPTH-1:0]       o_ent_vld
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset: a zero count already marks every slot as stale.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] w_off;
        assign w_off        = PW'(g) - r_rptr;
        assign o_ent_vld[g] = ({1'b0, w_off} < r_count);
        assign o_ent_rd[g]  = r_mem[g].rd;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: merges the ALU (priority) and buffered LU results into one
// registered write per cycle, with starvation relief for the LU and a pending-write hazard query.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = WB_DATA_W,
    parameter int REG_DATA_WIDTH = WB_REG_W,
    parameter int FIFO_DEPTH     = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT   = WB_STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [REG_DATA_WIDTH-1:0]     alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [REG_DATA_WIDTH-1:0]     lu_rd,
    input  logic [DATA_WIDTH-1:0]         lu_result,
    input  logic [REG_DATA_WIDTH-1:0]     rs1,
    input  logic [REG_DATA_WIDTH-1:0]     rs2,
    input  logic [REG_DATA_WIDTH-1:0]     issue_rd,
    output logic                          pend_hit,
    output logic                          alu_stall,
    output logic                          RegWrite,
    output logic [REG_DATA_WIDTH-1:0]     rd,
    output logic [DATA_WIDTH-1:0]         ResultW,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    wb_entry_t                     w_head;
    wb_entry_t                     w_lu_entry;
    logic [$clog2(FIFO_DEPTH):0]   w_count;
    logic                          w_full;
    logic                          w_empty;
    logic [REG_DATA_WIDTH-1:0]     w_ent_rd [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]         w_ent_vld;

    logic                          w_lu_xfer;
    logic                          w_alu_req;
    logic                          w_alu_sel;
    logic                          w_fifo_sel;
    logic                          w_byp_sel;
    logic                          w_push;
    logic                          w_wr_en;
    logic [REG_DATA_WIDTH-1:0]     w_wr_rd;
    logic [DATA_WIDTH-1:0]         w_wr_data;
    logic [SW-1:0]                 w_starve_inc;
    logic                          w_pend_hit;

    logic [SW-1:0]                 r_starve;
    logic                          r_alu_stall;
    logic                          r_reg_write;
    logic [REG_DATA_WIDTH-1:0]     r_rd;
    logic [DATA_WIDTH-1:0]         r_result;

    // No full-bypass: a simultaneous dequeue does not reopen a full FIFO.
    assign lu_ready   = !rst && !w_full;
    assign w_lu_xfer  = lu_valid && lu_ready;
    assign w_alu_req  = alu_valid && (alu_rd != '0);

    // alu_stall with a non-empty FIFO forces the head out even over a (protocol-violating) ALU result.
    assign w_alu_sel  = w_alu_req && !(r_alu_stall && !w_empty);
    assign w_fifo_sel = !w_empty && !w_alu_sel;
    assign w_byp_sel  = w_empty && !w_alu_sel && w_lu_xfer && (lu_rd != '0);
    assign w_push     = w_lu_xfer && (lu_rd != '0) && !w_byp_sel;

    assign w_lu_entry.rd   = lu_rd;
    assign w_lu_entry.data = lu_result;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_fifo_sel),
        .i_data    (w_lu_entry),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_ent_rd  (w_ent_rd),
        .o_ent_vld (w_ent_vld)
    );

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_rd   = '0;
        w_wr_data = '0;
        if (w_fifo_sel) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = w_head.rd;
            w_wr_data = w_head.data;
        end else if (w_alu_sel) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = alu_rd;
            w_wr_data = alu_result;
        end else if (w_byp_sel) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = lu_rd;
            w_wr_data = lu_result;
        end
    end

    always_comb begin
        w_pend_hit = w_lu_xfer && (rd_match(lu_rd, rs1) || rd_match(lu_rd, rs2) ||
                                   rd_match(lu_rd, issue_rd));
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_ent_vld[i] && (rd_match(w_ent_rd[i], rs1) || rd_match(w_ent_rd[i], rs2) ||
                                 rd_match(w_ent_rd[i], issue_rd)))
                w_pend_hit = 1'b1;
        end
    end

    assign w_starve_inc = r_starve + SW'(1);

    // Stage boundary: starvation counter and one-shot ALU stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve    <= '0;
            r_alu_stall <= 1'b0;
        end else begin
            r_alu_stall <= 1'b0;
            if (w_empty || w_fifo_sel) begin
                r_starve <= '0;
            end else if (w_alu_sel) begin
                r_starve    <= w_starve_inc;
                r_alu_stall <= (w_starve_inc == SW'(STARVE_LIMIT - 1));
            end
        end
    end

    // Stage boundary: registered register-file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_result    <= '0;
        end else begin
            r_reg_write <= w_wr_en;
            r_rd        <= w_wr_rd;
            r_result    <= w_wr_data;
        end
    end

    assign pend_hit   = w_pend_hit;
    assign alu_stall  = r_alu_stall;
    assign RegWrite   = r_reg_write;
    assign rd         = r_rd;
    assign ResultW    = r_result;
    assign fifo_count = w_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 4;
    localparam int SL    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [RW-1:0] alu_rd;
    logic [DW-1:0] alu_result;
    logic          lu_valid;
    logic          lu_ready;
    logic [RW-1:0] lu_rd;
    logic [DW-1:0] lu_result;
    logic [RW-1:0] rs1, rs2, issue_rd;
    logic          pend_hit;
    logic          alu_stall;
    logic          RegWrite;
    logic [RW-1:0] rd;
    logic [DW-1:0] ResultW;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_WIDTH     (DW),
        .REG_DATA_WIDTH (RW),
        .FIFO_DEPTH     (DEPTH),
        .STARVE_LIMIT   (SL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_result (alu_result),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_result  (lu_result),
        .rs1        (rs1),
        .rs2        (rs2),
        .issue_rd   (issue_rd),
        .pend_hit   (pend_hit),
        .alu_stall  (alu_stall),
        .RegWrite   (RegWrite),
        .rd         (rd),
        .ResultW    (ResultW),
        .fifo_count (fifo_count)
    );

    // The ALU must stay idle while alu_stall is high; an ALU result then would be lost.
    always @(posedge clk) begin
        assert (rst || !(alu_stall && alu_valid))
            else $error("alu result presented during alu_stall");
    end

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    int            starve;
    bit            m_stall;
    bit            m_xfer;
    bit            exp_we;
    logic [RW-1:0] exp_rd;
    logic [DW-1:0] exp_data;
    bit            exp_ready;
    bit            exp_pend;
    int            pass_cnt = 0;
    int            total    = 0;

    task automatic model_reset();
        q.delete();
        starve   = 0;
        m_stall  = 0;
        m_xfer   = 0;
        exp_we   = 0;
        exp_rd   = '0;
        exp_data = '0;
    endtask

    function automatic bit hits(logic [RW-1:0] r);
        return (rs1 != 0 && r == rs1) || (rs2 != 0 && r == rs2) || (issue_rd != 0 && r == issue_rd);
    endfunction

    // Let inputs settle, then derive the combinational expectations from the model queue.
    task automatic settle();
        #2;
        exp_ready = !rst && (q.size() < DEPTH);
        exp_pend  = 0;
        foreach (q[i]) if (hits(q[i].rd)) exp_pend = 1;
        if (lu_valid && exp_ready && hits(lu_rd)) exp_pend = 1;
    endtask

    // Apply the write-back rules to this cycle's inputs to predict the next registered state.
    task automatic model_step();
        bit ready, xfer, alu_req, deq, alu_won, byp, nstall;
        ready   = !rst && (q.size() < DEPTH);
        xfer    = lu_valid && ready;
        alu_req = alu_valid && (alu_rd != 0);
        deq = 0; alu_won = 0; byp = 0;
        if (m_stall && q.size() != 0)  deq = 1;
        else if (alu_req)              alu_won = 1;
        else if (q.size() != 0)        deq = 1;
        else if (xfer && lu_rd != 0)   byp = 1;
        exp_we = deq || alu_won || byp;
        exp_rd = '0; exp_data = '0;
        if (deq)          begin exp_rd = q[0].rd; exp_data = q[0].data;   end
        else if (alu_won) begin exp_rd = alu_rd;  exp_data = alu_result; end
        else if (byp)     begin exp_rd = lu_rd;   exp_data = lu_result;  end
        nstall = 0;
        if (q.size() == 0 || deq) starve = 0;
        else if (alu_won) begin
            starve++;
            nstall = (starve == SL - 1);
        end
        if (deq) void'(q.pop_front());
        if (xfer && lu_rd != 0 && !byp) q.push_back('{lu_rd, lu_result});
        m_stall = nstall;
        m_xfer  = xfer;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = '0; alu_result = '0;
        lu_valid = 0; lu_rd = '0; lu_result = '0;
        rs1 = '0; rs2 = '0; issue_rd = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite: got %0b want 0", RegWrite); else pass_cnt++;
        total++; if (fifo_count !== '0) $display("FAIL reset_count: got %0d want 0", fifo_count); else pass_cnt++;
        total++; if (alu_stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", alu_stall); else pass_cnt++;
        total++; if (lu_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", lu_ready); else pass_cnt++;
        rst = 0;
        // Queue three LU results behind a busy ALU, then reset mid-stream.
        alu_valid = 1; alu_rd = 5'd3; alu_result = 32'h3333;
        for (int k = 0; k < 3; k++) begin
            lu_valid = 1; lu_rd = RW'(10 + k); lu_result = 32'h100 + k;
            settle();
            tick();
        end
        total++; if (fifo_count !== CW'(3)) $display("FAIL midrst_fill: got %0d want 3", fifo_count); else pass_cnt++;
        rst = 1;
        model_reset();
        idle_inputs();
        #1;
        total++; if (fifo_count !== '0) $display("FAIL midrst_count: got %0d want 0", fifo_count); else pass_cnt++;
        total++; if (RegWrite !== 1'b0) $display("FAIL midrst_regwrite: got %0b want 0", RegWrite); else pass_cnt++;
        total++; if (lu_ready !== 1'b0) $display("FAIL midrst_ready: got %0b want 0", lu_ready); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            settle();
            tick();
            total++; if (RegWrite !== 1'b0) $display("FAIL midrst_ghost: got %0b want 0 (cycle %0d)", RegWrite, k); else pass_cnt++;
        end
    endtask

    task automatic test_alu_only();
        idle_inputs();
        alu_valid = 1; alu_rd = 5'd5; alu_result = 32'h1234;
        settle();
        tick();
        alu_valid = 0;
        total++; if (RegWrite !== 1'b1) $display("FAIL alu_regwrite: got %0b want 1", RegWrite); else pass_cnt++;
        total++; if (rd !== 5'd5) $display("FAIL alu_rd: got %0d want 5", rd); else pass_cnt++;
        total++; if (ResultW !== 32'h1234) $display("FAIL alu_data: got %h want 00001234", ResultW); else pass_cnt++;
    endtask

    task automatic test_bypass();
        idle_inputs();
        lu_valid = 1; lu_rd = 5'd7; lu_result = 32'hAA;
        settle();
        total++; if (lu_ready !== 1'b1) $display("FAIL byp_ready: got %0b want 1", lu_ready); else pass_cnt++;
        tick();
        lu_valid = 0;
        total++; if (RegWrite !== 1'b1 || rd !== 5'd7 || ResultW !== 32'hAA)
            $display("FAIL byp_write: got we=%0b rd=%0d data=%h want we=1 rd=7 data=000000aa", RegWrite, rd, ResultW);
        else pass_cnt++;
        total++; if (fifo_count !== '0) $display("FAIL byp_count: got %0d want 0", fifo_count); else pass_cnt++;
    endtask

    task automatic test_full_fifo();
        int sent = 0;
        int cyc  = 0;
        bit full_checked = 0;
        idle_inputs();
        while (sent < 5 || q.size() != 0) begin
            if (cyc >= 150) begin
                total++; $display("FAIL full_timeout: got %0d entries left want 0", q.size());
                break;
            end
            alu_valid = !m_stall; alu_rd = RW'(1 + cyc % 30); alu_result = $urandom;
            if (sent < 5 && !lu_valid) begin
                lu_valid = 1; lu_rd = RW'(16 + sent); lu_result = $urandom;
            end
            settle();
            if (sent == 4 && !full_checked) begin
                full_checked = 1;
                total++; if (lu_ready !== 1'b0) $display("FAIL full_ready: got %0b want 0", lu_ready); else pass_cnt++;
                total++; if (fifo_count !== CW'(4)) $display("FAIL full_count: got %0d want 4", fifo_count); else pass_cnt++;
            end
            total++; if (lu_ready !== exp_ready) $display("FAIL full_ready_trk: got %0b want %0b", lu_ready, exp_ready); else pass_cnt++;
            tick();
            if (m_xfer) begin sent++; lu_valid = 0; end
            total++; if (RegWrite !== exp_we || (exp_we && (rd !== exp_rd || ResultW !== exp_data)))
                $display("FAIL full_write: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                         RegWrite, rd, ResultW, exp_we, exp_rd, exp_data);
            else pass_cnt++;
            cyc++;
        end
        alu_valid = 0;
    endtask

    task automatic test_starvation();
        int stall_seen = 0;
        idle_inputs();
        alu_valid = 1; alu_rd = 5'd2; alu_result = 32'h2;
        lu_valid = 1; lu_rd = 5'd21; lu_result = 32'hBEEF;
        settle();
        tick();
        lu_valid = 0;
        for (int k = 1; k <= 12; k++) begin
            alu_valid = !m_stall;
            settle();
            tick();
            if (alu_stall === 1'b1) stall_seen++;
            total++; if (alu_stall !== (k == 7)) $display("FAIL starve_stall: got %0b want %0b (cycle %0d)", alu_stall, (k == 7), k); else pass_cnt++;
            if (k == 8) begin
                total++; if (RegWrite !== 1'b1 || rd !== 5'd21 || ResultW !== 32'hBEEF)
                    $display("FAIL starve_head: got we=%0b rd=%0d data=%h want we=1 rd=21 data=0000beef", RegWrite, rd, ResultW);
                else pass_cnt++;
            end
        end
        total++; if (stall_seen != 1) $display("FAIL starve_once: got %0d want 1", stall_seen); else pass_cnt++;
        alu_valid = 0;
        settle();
        tick();
    endtask

    task automatic test_x0_hazard();
        idle_inputs();
        alu_valid = 1; alu_rd = 5'd0; alu_result = 32'hDEAD;
        settle();
        tick();
        total++; if (RegWrite !== 1'b0) $display("FAIL x0_alu: got %0b want 0", RegWrite); else pass_cnt++;
        alu_rd = 5'd4; alu_result = 32'h44;
        lu_valid = 1; lu_rd = 5'd0; lu_result = 32'hF00;
        settle();
        total++; if (lu_ready !== 1'b1) $display("FAIL x0_lu_ready: got %0b want 1", lu_ready); else pass_cnt++;
        tick();
        total++; if (fifo_count !== '0) $display("FAIL x0_lu_count: got %0d want 0", fifo_count); else pass_cnt++;
        total++; if (RegWrite !== 1'b1 || rd !== 5'd4) $display("FAIL x0_alu4: got we=%0b rd=%0d want we=1 rd=4", RegWrite, rd); else pass_cnt++;
        lu_rd = 5'd9; lu_result = 32'h99; rs2 = 5'd9;
        settle();
        total++; if (pend_hit !== 1'b1) $display("FAIL haz_input: got %0b want 1", pend_hit); else pass_cnt++;
        tick();
        lu_valid = 0; alu_valid = 0;
        settle();
        total++; if (pend_hit !== 1'b1) $display("FAIL haz_queued: got %0b want 1", pend_hit); else pass_cnt++;
        total++; if (fifo_count !== CW'(1)) $display("FAIL haz_count: got %0d want 1", fifo_count); else pass_cnt++;
        tick();
        total++; if (RegWrite !== 1'b1 || rd !== 5'd9 || ResultW !== 32'h99)
            $display("FAIL haz_drain: got we=%0b rd=%0d data=%h want we=1 rd=9 data=00000099", RegWrite, rd, ResultW);
        else pass_cnt++;
        settle();
        total++; if (pend_hit !== 1'b0) $display("FAIL haz_clear: got %0b want 0", pend_hit); else pass_cnt++;
        rs2 = '0;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst = 1;
                model_reset();
                idle_inputs();
                #1;
                total++; if (fifo_count !== '0 || RegWrite !== 1'b0)
                    $display("FAIL rnd_reset: got count=%0d we=%0b want 0 0", fifo_count, RegWrite);
                else pass_cnt++;
                @(posedge clk);
                #1;
                rst = 0;
            end
            if (!lu_valid && $urandom_range(0, 2) == 0) begin
                lu_valid  = 1;
                lu_rd     = ($urandom_range(0, 3) == 0) ? RW'(0) : RW'($urandom_range(1, 15));
                lu_result = $urandom;
            end
            alu_valid  = !m_stall && ($urandom_range(0, 99) < 70);
            alu_rd     = RW'($urandom_range(0, 12));
            alu_result = $urandom;
            rs1        = RW'($urandom_range(0, 15));
            rs2        = RW'($urandom_range(0, 15));
            issue_rd   = RW'($urandom_range(0, 15));
            settle();
            total++; if (lu_ready !== exp_ready) $display("FAIL rnd_ready: got %0b want %0b (cycle %0d)", lu_ready, exp_ready, c); else pass_cnt++;
            total++; if (pend_hit !== exp_pend) $display("FAIL rnd_pend: got %0b want %0b (cycle %0d)", pend_hit, exp_pend, c); else pass_cnt++;
            tick();
            if (m_xfer) lu_valid = 0;
            total++; if (RegWrite !== exp_we || (exp_we && (rd !== exp_rd || ResultW !== exp_data)))
                $display("FAIL rnd_write: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h (cycle %0d)",
                         RegWrite, rd, ResultW, exp_we, exp_rd, exp_data, c);
            else pass_cnt++;
            total++; if (fifo_count !== CW'(q.size())) $display("FAIL rnd_count: got %0d want %0d (cycle %0d)", fifo_count, q.size(), c); else pass_cnt++;
            total++; if (alu_stall !== m_stall) $display("FAIL rnd_stall: got %0b want %0b (cycle %0d)", alu_stall, m_stall, c); else pass_cnt++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_bypass();
        test_full_fifo();
        test_starvation();
        test_x0_hazard();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the single register-file write port (write enable `RegWrite`, write address `rd`, write data `ResultW`).
- Merges two result producers into one registered write per cycle:
  - the single-cycle ALU, which has priority and no backpressure;
  - the multi-cycle load/mul-div unit (LU), which uses a valid/ready handshake and is buffered in a small FIFO.
- Provides a pending-write query that the decode stage uses to stall on RAW/WAW hazards against buffered LU results.
- Sits between the execute/memory units and the register file. The register file captures the outputs on the following negedge.

## Interface
Parameters:
- `DATA_WIDTH`, 32, result width
- `REG_DATA_WIDTH`, 5, register address width
- `FIFO_DEPTH`, 4, LU buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, consecutive cycles a non-empty FIFO may be held off by the ALU

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in `REG_DATA_WIDTH`: ALU destination register.
- `alu_result` in `DATA_WIDTH`: ALU result.
- `lu_valid` in 1: LU result offered.
- `lu_ready` out 1: arbiter accepts the LU result.
- `lu_rd` in `REG_DATA_WIDTH`: LU destination register.
- `lu_result` in `DATA_WIDTH`: LU result.
- `rs1`, `rs2`, `issue_rd` in `REG_DATA_WIDTH`: decode-stage source registers and destination register, for hazard query.
- `pend_hit` out 1: combinational; hazard against a buffered LU write.
- `alu_stall` out 1: registered; the ALU must present no result next cycle.
- `RegWrite` out 1: register-file write enable.
- `rd` out `REG_DATA_WIDTH`: register-file write address.
- `ResultW` out `DATA_WIDTH`: register-file write data.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: number of occupied FIFO entries.

## Operation
- LU handshake:
  - `lu_ready = !rst && (fifo_count < FIFO_DEPTH)`.
  - A transfer occurs on a posedge where `lu_valid && lu_ready`.
  - When the FIFO is full, `lu_ready` stays 0 even if a dequeue happens in the same cycle (no full-bypass).
  - `lu_valid` must stay high with stable `lu_rd`/`lu_result` until the transfer occurs.
- Writes with destination `x0`:
  - A transferred LU result with `lu_rd==0` is accepted and dropped, never stored.
  - An ALU result with `alu_rd==0` produces no write.
- Per-cycle selection for the next registered write, in priority order:
  1. `alu_stall` currently high and FIFO non-empty → FIFO head.
  2. `alu_valid && alu_rd!=0` → ALU.
  3. FIFO non-empty → FIFO head, which is dequeued.
  4. FIFO empty and an LU transfer with `lu_rd!=0` → LU input directly (bypass; not enqueued).
  5. Otherwise `RegWrite` is 0 next cycle.
- When the ALU wins and the LU transfers in the same cycle, the LU result is enqueued.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the ALU wins.
  - Clears on any FIFO dequeue or when the FIFO is empty.
  - When it reaches `STARVE_LIMIT-1`, `alu_stall` is registered high for exactly one cycle.
  - Upstream guarantees `alu_valid=0` during `alu_stall`. If `alu_valid` is nonetheless high, the ALU result is lost; the bench flags this with an assertion.
- `pend_hit` is 1 when any valid FIFO entry, or the LU input being accepted this cycle, has an `rd` equal to a nonzero `rs1`, `rs2` or `issue_rd`.
- FIFO read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo `FIFO_DEPTH`. `fifo_count` is tracked separately.
- Entries drain in arrival order.

## Timing
- ALU result in cycle N → `RegWrite`/`rd`/`ResultW` valid throughout cycle N+1; the register file writes on the negedge of N+1.
- Bypassed LU result (FIFO empty, ALU idle): same latency of 1 cycle.
- Buffered LU result: at least 1 cycle after enqueue.
- Worst-case hold-off is `STARVE_LIMIT` cycles while the FIFO is non-empty.
- `fifo_count` and `alu_stall` update on posedge; `pend_hit` and `lu_ready` are combinational.
- Reset, including when asserted mid-operation:
  - `RegWrite`, `rd`, `ResultW`, `alu_stall` = 0.
  - `fifo_count` = 0, pointers = 0, starvation counter = 0.
  - Buffered entries are discarded.
  - `lu_ready` = 0 while `rst` is high.

## Structure
- Shared package `wb_pkg`:
  - `wb_entry_t` struct: `{rd, data}`.
  - Default width constants.
- Sub-module `wb_fifo`:
  - Parameterised synchronous FIFO of `wb_entry_t`.
  - Ports: push, pop, head, count, full, empty.
  - Exposes all valid entries' `rd` fields for the hazard compare.
- Top level contains the select logic, output register, starvation counter and `pend_hit` compare.

## Test plan
- Reset mid-stream:
  - Stimulus: 3 LU results queued, assert `rst`.
  - Required: `fifo_count=0`, `RegWrite=0` immediately; no queued write ever appears.
- ALU only:
  - Stimulus: `alu_valid`, `alu_rd=5`, `alu_result=0x1234` in cycle N.
  - Required: `RegWrite=1`, `rd=5`, `ResultW=0x1234` in cycle N+1.
- Bypass:
  - Stimulus: idle ALU, LU `rd=7`, data `0xAA`.
  - Required: write in the next cycle; `fifo_count` stays 0.
- Full FIFO:
  - Stimulus: ALU busy every cycle; LU offers 5 results.
  - Required: `lu_ready=0` after 4 accepts; `fifo_count=4`.
- Starvation:
  - Stimulus: ALU busy continuously with one LU entry queued.
  - Required: `alu_stall` high once after 8 cycles; FIFO head written the following cycle.
- x0 and hazard:
  - Stimulus: ALU `rd=0` → no write. LU `rd=0` accepted → `fifo_count` unchanged. Queued `rd=9` with `rs2=9` → `pend_hit=1`.
  - Required: `pend_hit` drops after the `rd=9` entry drains.
